// File: rtl/div_unit_pkg.sv
// Shared control codes and divider state encoding for the EX-stage divider.
package div_unit_pkg;

    localparam logic [4:0] ADD_CONTROL  = 5'b00010;
    localparam logic [4:0] DIV_CONTROL  = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL = 5'b11011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem, quot} left, subtract divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_nx,
    output logic [WIDTH-1:0] quot_nx
);

    // Extra top bit makes the borrow of the trial subtraction visible as a sign.
    logic [WIDTH+1:0] trial;
    logic             neg;

    assign trial   = {rem, quot[WIDTH-1]} - {2'b00, divisor};
    assign neg     = trial[WIDTH+1];
    assign rem_nx  = neg ? {rem[WIDTH-1:0], quot[WIDTH-1]} : trial[WIDTH:0];
    assign quot_nx = {quot[WIDTH-2:0], ~neg};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; stalls the pipeline while iterating.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CTRL_W-1:0]    alucontrol,
    input  logic                 ex_valid,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 stall_req,
    output logic                 result_valid,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] dvsr;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quot_nx;
    logic [WIDTH-1:0] rem_fin;
    logic [WIDTH-1:0] quot_fin;
    logic             is_signed;
    logic             is_div;
    logic             start;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign is_signed = (alucontrol == CTRL_W'(DIV_CONTROL));
    assign is_div    = is_signed | (alucontrol == CTRL_W'(DIVU_CONTROL));
    assign start     = ex_valid & ~annul & is_div;

    assign a_mag = (is_signed & a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed & b[WIDTH-1]) ? -b : b;

    // Stall is asserted in the very cycle a divide is seen so EX never advances past it.
    assign stall_req    = (state == DIV_IDLE) ? start : (state == DIV_BUSY);
    assign result_valid = (state == DIV_DONE) & ~annul;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quot    (quot),
        .divisor (dvsr),
        .rem_nx  (rem_nx),
        .quot_nx (quot_nx)
    );

    assign rem_fin  = sign_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
    assign quot_fin = sign_q ? -quot_nx : quot_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quot   <= '0;
            dvsr   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            result <= {a, {WIDTH{1'b1}}};
                            state  <= DIV_DONE;
                        end else begin
                            quot   <= a_mag;
                            dvsr   <= b_mag;
                            rem    <= '0;
                            sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            sign_r <= is_signed & a[WIDTH-1];
                            cnt    <= '0;
                            state  <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        rem  <= rem_nx;
                        quot <= quot_nx;
                        cnt  <= cnt + 1'b1;
                        // Result is latched on the final iteration so it is stable during DONE.
                        if (cnt == CW'(WIDTH-1)) begin
                            result <= {rem_fin, quot_fin};
                            state  <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signs, divide-by-zero, annul, reset.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alucontrol;
    logic        ex_valid;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_req;
    logic        result_valid;
    logic [63:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] held   = '0;

    div_unit #(.WIDTH(32), .CTRL_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .alucontrol   (alucontrol),
        .ex_valid     (ex_valid),
        .annul        (annul),
        .a            (a),
        .b            (b),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Runs one divide; ex_valid drops after DONE (or after the annul cycle).
    task automatic do_div(input logic [4:0] ctrl, input logic [31:0] av, input logic [31:0] bv,
                          input int lat, input logic [63:0] exp, input int annul_at, input string tag);
        int last;
        last = (annul_at >= 0) ? annul_at + 2 : lat + 1;
        for (int cyc = 0; cyc <= last; cyc++) begin
            alucontrol = ctrl;
            a          = av;
            b          = bv;
            ex_valid   = (annul_at >= 0) ? (cyc <= annul_at) : (cyc <= lat);
            annul      = (cyc == annul_at);
            @(negedge clk);
            chk($sformatf("%s stall c%0d", tag, cyc), 64'(stall_req),
                64'((annul_at >= 0) ? (cyc <= annul_at) : (cyc < lat)));
            chk($sformatf("%s valid c%0d", tag, cyc), 64'(result_valid),
                64'((annul_at < 0) && (cyc == lat)));
            if (annul_at < 0 && cyc == lat) begin
                chk({tag, " result"}, result, exp);
                held = exp;
            end
            @(posedge clk); #1;
        end
        annul    = 1'b0;
        ex_valid = 1'b0;
        chk({tag, " hold"}, result, held);
    endtask

    initial begin
        rst        = 1'b1;
        alucontrol = ADD_CONTROL;
        ex_valid   = 1'b0;
        annul      = 1'b0;
        a          = '0;
        b          = '0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("reset stall", 64'(stall_req), 64'd0);
        chk("reset valid", 64'(result_valid), 64'd0);
        chk("reset result", result, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_div(DIVU_CONTROL, 32'd100, 32'd7, 33, {32'h00000002, 32'h0000000E}, -1, "divu100_7");
        do_div(DIV_CONTROL, 32'hFFFFFFF9, 32'd2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, -1, "div_m7_2");
        do_div(DIV_CONTROL, 32'h80000000, 32'hFFFFFFFF, 33, {32'h00000000, 32'h80000000}, -1, "div_ovf");
        do_div(DIVU_CONTROL, 32'h12345678, 32'd0, 1, {32'h12345678, 32'hFFFFFFFF}, -1, "divu_by0");
        do_div(DIVU_CONTROL, 32'hFFFFFFFF, 32'd1, 33, 64'd0, 10, "annul");
        do_div(DIVU_CONTROL, 32'd9, 32'd3, 33, {32'h00000000, 32'h00000003}, -1, "divu9_3");

        // Reset mid-division.
        alucontrol = DIV_CONTROL;
        a          = 32'd1000;
        b          = 32'd3;
        ex_valid   = 1'b1;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            rst = (cyc == 20);
            @(negedge clk);
            chk($sformatf("rst_div stall c%0d", cyc), 64'(stall_req), 64'd1);
            @(posedge clk); #1;
        end
        rst      = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("post_rst stall", 64'(stall_req), 64'd0);
        chk("post_rst valid", 64'(result_valid), 64'd0);
        chk("post_rst result", result, 64'd0);
        held = '0;
        @(posedge clk); #1;

        alucontrol = ADD_CONTROL;
        ex_valid   = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            chk($sformatf("add stall c%0d", cyc), 64'(stall_req), 64'd0);
            chk($sformatf("add valid c%0d", cyc), 64'(result_valid), 64'd0);
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;

        // Back-to-back: second DIV enters EX as the first leaves in DONE.
        alucontrol = DIV_CONTROL;
        for (int cyc = 0; cyc <= 68; cyc++) begin
            ex_valid = (cyc <= 67);
            a        = (cyc < 33) ? 32'hFFFFFF9C : 32'd50;
            b        = (cyc < 33) ? 32'd7 : 32'hFFFFFFFA;
            @(negedge clk);
            chk($sformatf("b2b stall c%0d", cyc), 64'(stall_req),
                64'((cyc < 33) || (cyc >= 34 && cyc < 67)));
            chk($sformatf("b2b valid c%0d", cyc), 64'(result_valid),
                64'((cyc == 33) || (cyc == 67)));
            if (cyc == 33) chk("b2b first result", result, {32'hFFFFFFFE, 32'hFFFFFFF2});
            if (cyc == 67) chk("b2b second result", result, {32'h00000002, 32'hFFFFFFF8});
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage.
- Consumes the 5-bit alucontrol produced by the ALU decoder and acts only on DIV_CONTROL and DIVU_CONTROL.
- Holds the pipeline through stall_req while it iterates.
- Hands {remainder, quotient} to the HI/LO write path as a one-cycle result_valid pulse.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are WIDTH bits each.
- CTRL_W, 5, width of alucontrol.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- alucontrol  in  CTRL_W  EX-stage ALU control code.
- ex_valid  in  1  EX holds a real, non-bubble instruction.
- annul  in  1  exception/flush for the EX instruction; aborts any division.
- a  in  WIDTH  dividend (rs).
- b  in  WIDTH  divisor (rt).
- stall_req  out  1  request that IF/ID/EX freeze.
- result_valid  out  1  one-cycle pulse; result holds the final value.
- result  out  2*WIDTH  {remainder (HI), quotient (LO)}.

Behaviour:
- start = ex_valid & ~annul & (alucontrol==DIV_CONTROL | alucontrol==DIVU_CONTROL); is_signed = (alucontrol==DIV_CONTROL).
- Reset: state IDLE, counter 0, stall_req 0, result_valid 0, result 0. Reset overrides every state, including mid-division.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall_req = start (combinational, same cycle).
  - On start with b!=0: latch |a|, |b| (magnitudes when signed, raw values when unsigned), sign_q = a[31]^b[31], sign_r = a[31] (both forced 0 when unsigned); clear partial remainder; counter = 0; go to BUSY.
  - On start with b==0: load quotient 0xFFFFFFFF and remainder = a unmodified; go to DONE.
  - With no start: stay in IDLE.
- BUSY:
  - stall_req = 1.
  - Each cycle: shift {rem, quot} left 1; trial = rem - divisor (33-bit). If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - counter increments; after the WIDTH-th iteration (counter==WIDTH-1) go to DONE.
- DONE:
  - stall_req = 0; result_valid = 1 for exactly this cycle.
  - result = {sign_r ? -rem : rem, sign_q ? -quot : quot}; result holds this value until the next start.
  - Always go to IDLE next. start is ignored in DONE, because the same instruction leaves EX on this edge.
- Latency: start in cycle 0, BUSY cycles 1..32, result_valid in cycle 33 (34 cycles in total). Divide-by-zero: result_valid in cycle 1.
- annul:
  - Asserted in BUSY: go to IDLE next cycle, no result_valid, stall_req drops the following cycle, result unchanged.
  - Asserted in DONE: suppresses result_valid in that cycle.
  - Asserted in IDLE: blocks start.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): magnitudes 0x80000000/1, quotient 0x80000000 after negation, remainder 0. No trap.
- Non-divide alucontrol codes never change state.
- Width rules: magnitudes are WIDTH-bit unsigned; the partial remainder is WIDTH+1 bits; negation is two's complement mod 2^WIDTH.

Decomposition:
- defines2.vh gets the DIV_IDLE/DIV_BUSY/DIV_DONE state encodings (2 bits). DIV_CONTROL and DIVU_CONTROL already live there and are used as-is.
- One combinational sub-module, div_step: inputs {rem, quot, divisor}; outputs the next {rem, quot} for a single restoring iteration. div_unit instantiates it once.
- Sign conditioning and the FSM stay in div_unit.

Test Plan:
1. DIVU a=100, b=7 -> stall_req high for cycles 0..32, result_valid at cycle 33, result={0x00000002, 0x0000000E}.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> result={0xFFFFFFFF, 0xFFFFFFFD}; then DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
3. DIVU a=0x12345678, b=0 -> result_valid at cycle 1, result={0x12345678, 0xFFFFFFFF}, stall_req high only in cycle 0.
4. DIVU 0xFFFFFFFF/1 started, annul at cycle 10 -> no result_valid, stall_req 0 from cycle 11. A new DIVU 9/3 then gives {0, 3} with full 34-cycle latency.
5. rst pulse at cycle 20 of a DIV -> all outputs 0 the next cycle, state IDLE, no result_valid. alucontrol=ADD_CONTROL with ex_valid=1 -> stall_req stays 0.
6. Back-to-back DIV instructions (second one held in EX during DONE) -> second start accepted in the cycle after DONE, two distinct result_valid pulses, no duplicate start.
